// File: rtl/digiota_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : digiota_pkg
//  Description : Shared state encoding and defaults for the OTA channel
//                scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package digiota_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_COMMIT = 3'd4
    } state_e;

    localparam int N_CH_DEF     = 4;
    localparam int SETTLE_DEF   = 3;
    localparam int AVG_LOG2_DEF = 2;

    function automatic int sample_n(input int avg_log2);
        return 1 << avg_log2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/digiota_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : digiota_rr_pick
//  Description : Combinational round-robin finder: first set mask bit at or
//                after ptr (wrapping), plus whether it is the highest set bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module digiota_rr_pick #(
    parameter int N_CH  = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_CH-1:0]  mask,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] idx,
    output logic             any,
    output logic             is_last
);

    logic [PTR_W:0]   w_dist [N_CH];
    logic [PTR_W:0]   w_best_dist;
    logic [PTR_W-1:0] w_hi_idx;

    // Distance of each channel from ptr going upward with wrap.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_dist
            assign w_dist[gi] = ((PTR_W+1)'(gi) >= {1'b0, ptr})
                              ? ((PTR_W+1)'(gi) - {1'b0, ptr})
                              : ((PTR_W+1)'(gi + N_CH) - {1'b0, ptr});
        end
    endgenerate

    always_comb begin
        idx         = '0;
        w_hi_idx    = '0;
        w_best_dist = (PTR_W+1)'(N_CH);
        for (int i = 0; i < N_CH; i++) begin
            if (mask[i] && (w_dist[i] < w_best_dist)) begin
                w_best_dist = w_dist[i];
                idx         = PTR_W'(i);
            end
            if (mask[i]) begin
                w_hi_idx = PTR_W'(i);
            end
        end
    end

    assign any     = |mask;
    assign is_last = any && (idx == w_hi_idx);

endmodule
`default_nettype wire

// File: rtl/digiota_chan_sched.sv
`default_nettype none
// ============================================================================
//  Module      : digiota_chan_sched
//  Description : Round-robin sequencer time-sharing one digital-OTA comparator
//                among N_CH channels with settle, multi-sample majority vote.
//  Revision    : 1.0 - initial release
// ============================================================================
module digiota_chan_sched
    import digiota_pkg::*;
#(
    parameter int N_CH       = N_CH_DEF,
    parameter int SETTLE_CYC = SETTLE_DEF,
    parameter int AVG_LOG2   = AVG_LOG2_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic [N_CH-1:0]         ch_mask,
    input  logic                    cmp_valid,
    input  logic                    cmp_out,
    output logic [$clog2(N_CH)-1:0] sel,
    output logic                    ota_en,
    output logic [N_CH-1:0]         result,
    output logic [N_CH-1:0]         result_vld,
    output logic                    frame_done,
    output logic                    timeout_err
);

    localparam int PTR_W    = $clog2(N_CH);
    localparam int SAMPLE_N = sample_n(AVG_LOG2);
    localparam int CNT_W    = AVG_LOG2 + 1;
    localparam int SET_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [2:0] c_ST_IDLE   = ST_IDLE;
    localparam logic [2:0] c_ST_SELECT = ST_SELECT;
    localparam logic [2:0] c_ST_SETTLE = ST_SETTLE;
    localparam logic [2:0] c_ST_SAMPLE = ST_SAMPLE;
    localparam logic [2:0] c_ST_COMMIT = ST_COMMIT;

    logic [2:0]       r_state;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] r_sel;
    logic             r_last;
    logic [SET_W-1:0] r_settle_cnt;
    logic [CNT_W-1:0] r_samp_cnt;
    logic [CNT_W-1:0] r_ones_cnt;
    logic [CNT_W-1:0] r_valid_cnt;
    logic [N_CH-1:0]  r_result;
    logic [N_CH-1:0]  r_result_vld;
    logic             r_frame_done;
    logic             r_timeout_err;

    logic [PTR_W-1:0] w_pick_idx;
    logic             w_pick_any;
    logic             w_pick_last;
    logic             w_run;
    logic             w_no_samples;
    logic [CNT_W:0]   w_ones_x2;
    logic [CNT_W:0]   w_valid_ext;
    logic [PTR_W-1:0] w_ptr_next;
    logic [N_CH-1:0]  w_result_next;
    logic [N_CH-1:0]  w_vld_next;

    digiota_rr_pick #(
        .N_CH  (N_CH),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .mask    (ch_mask),
        .ptr     (r_ptr),
        .idx     (w_pick_idx),
        .any     (w_pick_any),
        .is_last (w_pick_last)
    );

    assign w_run        = ena && (|ch_mask);
    assign w_no_samples = (r_valid_cnt == '0);
    assign w_ones_x2    = {r_ones_cnt, 1'b0};
    assign w_valid_ext  = {1'b0, r_valid_cnt};
    assign w_ptr_next   = (r_sel == PTR_W'(N_CH - 1)) ? '0 : (r_sel + PTR_W'(1));

    // Vote on commit; a tie keeps the previous bit. Masked-off channels lose valid.
    always_comb begin
        w_result_next = r_result;
        w_vld_next    = r_result_vld;
        if (r_state == c_ST_COMMIT) begin
            if (w_no_samples) begin
                w_vld_next[r_sel] = 1'b0;
            end else begin
                w_vld_next[r_sel] = 1'b1;
                if (w_ones_x2 > w_valid_ext) begin
                    w_result_next[r_sel] = 1'b1;
                end else if (w_ones_x2 < w_valid_ext) begin
                    w_result_next[r_sel] = 1'b0;
                end
            end
        end
        w_vld_next = w_vld_next & ch_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_ST_IDLE;
            r_ptr         <= '0;
            r_sel         <= '0;
            r_last        <= 1'b0;
            r_settle_cnt  <= '0;
            r_samp_cnt    <= '0;
            r_ones_cnt    <= '0;
            r_valid_cnt   <= '0;
            r_result      <= '0;
            r_result_vld  <= '0;
            r_frame_done  <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_result      <= w_result_next;
            r_result_vld  <= w_vld_next;
            r_frame_done  <= (r_state == c_ST_COMMIT) && r_last;
            r_timeout_err <= (r_state == c_ST_COMMIT) && w_no_samples;

            case (r_state)
                c_ST_IDLE: begin
                    if (w_run) begin
                        r_state <= c_ST_SELECT;
                    end
                end
                c_ST_SELECT: begin
                    if (!ena || !w_pick_any) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_sel        <= w_pick_idx;
                        r_last       <= w_pick_last;
                        r_settle_cnt <= SET_W'(SETTLE_CYC - 1);
                        r_ones_cnt   <= '0;
                        r_valid_cnt  <= '0;
                        r_state      <= c_ST_SETTLE;
                    end
                end
                c_ST_SETTLE: begin
                    if (!ena) begin
                        r_state <= c_ST_IDLE;
                    end else if (r_settle_cnt == '0) begin
                        r_samp_cnt <= '0;
                        r_state    <= c_ST_SAMPLE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - SET_W'(1);
                    end
                end
                c_ST_SAMPLE: begin
                    if (!ena) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        if (cmp_valid) begin
                            r_valid_cnt <= r_valid_cnt + CNT_W'(1);
                            r_ones_cnt  <= r_ones_cnt + CNT_W'(cmp_out);
                        end
                        if (r_samp_cnt == CNT_W'(SAMPLE_N - 1)) begin
                            r_state <= c_ST_COMMIT;
                        end else begin
                            r_samp_cnt <= r_samp_cnt + CNT_W'(1);
                        end
                    end
                end
                c_ST_COMMIT: begin
                    r_ptr   <= w_ptr_next;
                    r_state <= w_run ? c_ST_SELECT : c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign sel         = r_sel;
    assign ota_en      = (r_state == c_ST_SETTLE) || (r_state == c_ST_SAMPLE);
    assign result      = r_result;
    assign result_vld  = r_result_vld;
    assign frame_done  = r_frame_done;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_digiota_chan_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_digiota_chan_sched
//  Description : Directed self-checking bench for digiota_chan_sched.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_digiota_chan_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [3:0] ch_mask;
    logic       cmp_valid;
    logic       cmp_out;
    logic [1:0] sel;
    logic       ota_en;
    logic [3:0] result;
    logic [3:0] result_vld;
    logic       frame_done;
    logic       timeout_err;

    int checks   = 0;
    int failures = 0;
    int fd_cnt   = 0;
    int to_cnt   = 0;
    int ota_cnt  = 0;

    always #5 clk = ~clk;

    digiota_chan_sched #(
        .N_CH       (4),
        .SETTLE_CYC (3),
        .AVG_LOG2   (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .ch_mask     (ch_mask),
        .cmp_valid   (cmp_valid),
        .cmp_out     (cmp_out),
        .sel         (sel),
        .ota_en      (ota_en),
        .result      (result),
        .result_vld  (result_vld),
        .frame_done  (frame_done),
        .timeout_err (timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        fd_cnt  += int'(frame_done);
        to_cnt  += int'(timeout_err);
        ota_cnt += int'(ota_en);
    endtask

    // Entered with the DUT in SELECT; returns just after the commit edge.
    task automatic chan(input string tag, input logic [1:0] exp_sel,
                        input logic [3:0] outs, input logic [3:0] vals);
        int on;
        on = 0;
        tick();
        check({tag, "_sel"}, 32'(sel), 32'(exp_sel));
        on += int'(ota_en);
        for (int k = 0; k < 3; k++) begin
            tick();
            on += int'(ota_en);
        end
        for (int k = 0; k < 4; k++) begin
            cmp_out   = outs[k];
            cmp_valid = vals[k];
            tick();
            on += int'(ota_en);
        end
        check({tag, "_ota_cycles"}, 32'(on), 32'd7);
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        ena       = 1'b0;
        ch_mask   = 4'b0000;
        cmp_valid = 1'b0;
        cmp_out   = 1'b0;
        #12;
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_ota", 32'(ota_en), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_vld", 32'(result_vld), 32'd0);
        check("rst_pulses", 32'({frame_done, timeout_err}), 32'd0);

        ch_mask = 4'b0101;
        #2 rst_n = 1'b1;
        tick(); tick(); tick();
        check("idle_ota", 32'(ota_en), 32'd0);

        // Basic frame: ch0 sees all ones, ch2 all zeros
        ena = 1'b1;
        tick();
        chan("basic_ch0", 2'd0, 4'b1111, 4'b1111);
        check("basic_ch0_res", 32'(result), 32'b0001);
        check("basic_ch0_vld", 32'(result_vld), 32'b0001);
        check("basic_ch0_fd", 32'(frame_done), 32'd0);
        chan("basic_ch2", 2'd2, 4'b0000, 4'b1111);
        check("basic_ch2_res", 32'(result), 32'b0001);
        check("basic_ch2_vld", 32'(result_vld), 32'b0101);
        check("basic_ch2_fd", 32'(frame_done), 32'd1);
        check("basic_fd_count", 32'(fd_cnt), 32'd1);

        // Tie hold on ch1
        ch_mask = 4'b0010;
        chan("tie_pre", 2'd1, 4'b1111, 4'b1111);
        check("tie_pre_res", 32'(result), 32'b0011);
        check("tie_pre_vld", 32'(result_vld), 32'b0010);
        chan("tie", 2'd1, 4'b0101, 4'b1111);
        check("tie_res", 32'(result), 32'b0011);
        check("tie_vld", 32'(result_vld), 32'b0010);
        check("tie_fd", 32'(frame_done), 32'd1);

        // Timeout on ch3, then a single valid sample gating out invalid ones
        ch_mask = 4'b1000;
        chan("to_pre", 2'd3, 4'b1111, 4'b1111);
        check("to_pre_res", 32'(result), 32'b1011);
        check("to_pre_vld", 32'(result_vld), 32'b1000);
        chan("to", 2'd3, 4'b1111, 4'b0000);
        check("to_pulse", 32'(timeout_err), 32'd1);
        check("to_res", 32'(result), 32'b1011);
        check("to_vld", 32'(result_vld), 32'b0000);
        chan("gate", 2'd3, 4'b1110, 4'b0001);
        check("to_single_pulse", 32'(to_cnt), 32'd1);
        check("gate_res", 32'(result), 32'b0011);
        check("gate_vld", 32'(result_vld), 32'b1000);

        // Abort during the second sample of ch1
        ch_mask = 4'b1111;
        chan("ab_ch0", 2'd0, 4'b0000, 4'b1111);
        check("ab_ch0_res", 32'(result), 32'b0010);
        check("ab_ch0_vld", 32'(result_vld), 32'b1001);
        check("ab_ch0_fd", 32'(frame_done), 32'd0);
        tick();
        check("ab_sel", 32'(sel), 32'd1);
        tick(); tick(); tick();
        cmp_out   = 1'b0;
        cmp_valid = 1'b1;
        tick();
        ena = 1'b0;
        tick();
        check("ab_ota", 32'(ota_en), 32'd0);
        check("ab_res", 32'(result), 32'b0010);
        check("ab_vld", 32'(result_vld), 32'b1001);
        tick(); tick();
        check("ab_idle_ota", 32'(ota_en), 32'd0);
        ena = 1'b1;
        tick();
        chan("ab_resume", 2'd1, 4'b0000, 4'b1111);
        check("ab_resume_res", 32'(result), 32'b0000);
        check("ab_resume_vld", 32'(result_vld), 32'b1011);

        // Idle guard: enabled with empty mask
        ch_mask = 4'b0000;
        ota_cnt = 0;
        for (int n = 0; n < 20; n++) tick();
        check("guard_ota", 32'(ota_cnt), 32'd0);
        check("guard_fd_count", 32'(fd_cnt), 32'd6);
        check("guard_to_count", 32'(to_cnt), 32'd1);
        check("guard_vld", 32'(result_vld), 32'b0000);
        ch_mask = 4'b1000;
        tick();
        chan("single_a", 2'd3, 4'b1111, 4'b1111);
        check("single_a_fd", 32'(frame_done), 32'd1);
        chan("single_b", 2'd3, 4'b1111, 4'b1111);
        check("single_b_fd", 32'(frame_done), 32'd1);
        check("single_fd_count", 32'(fd_cnt), 32'd8);
        check("single_res", 32'(result), 32'b1000);
        check("single_vld", 32'(result_vld), 32'b1000);

        // Asynchronous reset mid-SAMPLE
        ch_mask = 4'b1111;
        tick(); tick(); tick(); tick();
        cmp_out   = 1'b1;
        cmp_valid = 1'b1;
        tick();
        check("mid_ota", 32'(ota_en), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ota", 32'(ota_en), 32'd0);
        check("arst_res", 32'(result), 32'd0);
        check("arst_vld", 32'(result_vld), 32'd0);
        check("arst_sel_pulses", 32'({sel, frame_done, timeout_err}), 32'd0);
        ena = 1'b0;
        #3 rst_n = 1'b1;
        tick(); tick();
        check("post_rst_ota", 32'(ota_en), 32'd0);
        check("post_rst_sel", 32'(sel), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
